// File: rtl/lutram_pkg.sv
// Shared constants and elaboration helpers for the RAMD64E-backed FIFO.
package lutram_pkg;

    localparam int RAMD64E_ABITS  = 6;
    localparam int RAMD64E_WABITS = 8;
    localparam int MAX_SPACES     = 4;
    localparam int SPACE_W        = $clog2(MAX_SPACES);

    // Number of 64-entry address spaces needed for a given depth.
    function automatic int nspace(input int depth_log2);
        return 1 << (depth_log2 - RAMD64E_ABITS);
    endfunction

    function automatic bit depth_legal(input int depth_log2);
        return (depth_log2 >= RAMD64E_ABITS) && (depth_log2 <= RAMD64E_WABITS);
    endfunction

endpackage

// File: rtl/lutram_fifo_ctrl_if.sv
// Stream and cell-bank signals of the LUTRAM FIFO; slave is the controller's view.
interface lutram_fifo_ctrl_if
    import lutram_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 6
);
    localparam int NSPACE = nspace(DEPTH_LOG2);

    logic [WIDTH-1:0]          IN_DATA;
    logic                      IN_VALID;
    logic                      IN_READY;
    logic [WIDTH-1:0]          OUT_DATA;
    logic                      OUT_VALID;
    logic                      OUT_READY;
    logic [DEPTH_LOG2+1:0]     LEVEL;
    logic [RAMD64E_WABITS-1:0] RAM_WADR;
    logic                      RAM_WE;
    logic [WIDTH-1:0]          RAM_I;
    logic [RAMD64E_ABITS-1:0]  RAM_RADR;
    logic [NSPACE*WIDTH-1:0]   RAM_O;

    modport slave (
        input  IN_DATA, IN_VALID, OUT_READY, RAM_O,
        output IN_READY, OUT_DATA, OUT_VALID, LEVEL, RAM_WADR, RAM_WE, RAM_I, RAM_RADR
    );

    modport master (
        output IN_DATA, IN_VALID, OUT_READY, RAM_O,
        input  IN_READY, OUT_DATA, OUT_VALID, LEVEL, RAM_WADR, RAM_WE, RAM_I, RAM_RADR
    );

endinterface

// File: rtl/lutram_fifo_ptr.sv
// Wrapping FIFO pointer split into a 64-entry cell address and an address-space select.
module lutram_fifo_ptr
    import lutram_pkg::*;
#(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     inc,
    output logic [RAMD64E_ABITS-1:0] entry,
    output logic [SPACE_W-1:0]       space
);

    logic [DEPTH_LOG2-1:0] ptr_reg;
    logic [DEPTH_LOG2-1:0] ptr_next;

    always_comb begin
        ptr_next = ptr_reg;
        if (inc) begin
            ptr_next = ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    assign entry = ptr_reg[RAMD64E_ABITS-1:0];

    // Bits above the 64-entry cell address pick the address space.
    if (DEPTH_LOG2 > RAMD64E_ABITS) begin : g_space
        assign space = SPACE_W'(ptr_reg[DEPTH_LOG2-1:RAMD64E_ABITS]);
    end else begin : g_no_space
        assign space = '0;
    end

endmodule

// File: rtl/lutram_fifo_ctrl.sv
// FIFO controller for a RAMD64E bank: write-side fan-out, read mux and registered output stage.
module lutram_fifo_ctrl
    import lutram_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                CLK,
    input  logic                RST,
    lutram_fifo_ctrl_if.slave   bus
);

    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int NSPACE = nspace(DEPTH_LOG2);

    if (!depth_legal(DEPTH_LOG2)) begin : g_bad_depth
        $fatal(1, "lutram_fifo_ctrl: DEPTH_LOG2 must be 6, 7 or 8");
    end

    logic [DEPTH_LOG2:0]      ram_count_reg;
    logic [DEPTH_LOG2:0]      ram_count_next;
    logic [WIDTH-1:0]         out_data_reg;
    logic                     out_valid_reg;
    logic                     in_ready;
    logic                     wr_en;
    logic                     ld_en;
    logic [RAMD64E_ABITS-1:0] wr_entry;
    logic [RAMD64E_ABITS-1:0] rd_entry;
    logic [SPACE_W-1:0]       wr_space;
    logic [SPACE_W-1:0]       rd_space;
    logic [WIDTH-1:0]         space_data [MAX_SPACES];
    logic [WIDTH-1:0]         head;

    // Ready depends only on registered count so a same-cycle load never raises it.
    assign in_ready = !RST && (ram_count_reg != (DEPTH_LOG2+1)'(DEPTH));
    assign wr_en    = bus.IN_VALID && in_ready;
    assign ld_en    = (ram_count_reg != '0) && (!out_valid_reg || bus.OUT_READY);

    lutram_fifo_ptr #(.DEPTH_LOG2(DEPTH_LOG2)) u_wr_ptr (
        .clk   (CLK),
        .srst  (RST),
        .inc   (wr_en),
        .entry (wr_entry),
        .space (wr_space)
    );

    lutram_fifo_ptr #(.DEPTH_LOG2(DEPTH_LOG2)) u_rd_ptr (
        .clk   (CLK),
        .srst  (RST),
        .inc   (ld_en),
        .entry (rd_entry),
        .space (rd_space)
    );

    for (genvar gi = 0; gi < MAX_SPACES; gi++) begin : g_space_data
        if (gi < NSPACE) begin : g_used
            assign space_data[gi] = bus.RAM_O[gi*WIDTH +: WIDTH];
        end else begin : g_unused
            assign space_data[gi] = '0;
        end
    end

    assign head = space_data[rd_space];

    always_comb begin
        ram_count_next = ram_count_reg;
        if (wr_en && !ld_en) begin
            ram_count_next = ram_count_reg + 1'b1;
        end else if (ld_en && !wr_en) begin
            ram_count_next = ram_count_reg - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ram_count_reg <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            ram_count_reg <= ram_count_next;
            if (ld_en) begin
                out_data_reg  <= head;
                out_valid_reg <= 1'b1;
            end else if (out_valid_reg && bus.OUT_READY) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.IN_READY  = in_ready;
    assign bus.RAM_WE    = wr_en;
    assign bus.RAM_I     = bus.IN_DATA;
    assign bus.RAM_WADR  = {wr_space, wr_entry};
    assign bus.RAM_RADR  = rd_entry;
    assign bus.OUT_DATA  = out_data_reg;
    assign bus.OUT_VALID = out_valid_reg;
    assign bus.LEVEL     = (DEPTH_LOG2+2)'(ram_count_reg) + (DEPTH_LOG2+2)'(out_valid_reg);

endmodule

// File: tb/tb_lutram_fifo_ctrl.sv
// Randomised bench: DEPTH_LOG2=6 and 8 controllers share stimulus, each with its own cell bank and queue model.
module tb_lutram_fifo_ctrl;

    logic       clk;
    logic       rst;
    logic       iv;
    logic       ordy;
    logic [7:0] idata;

    int n_cmp;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int inst, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 50) begin
                $display("FAIL %s [d%0d] t=%0t: got %0h expected %0h", tag, inst, $time, got, exp);
            end
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int DL  = (gi == 0) ? 6 : 8;
        localparam int CAP = 1 << DL;
        localparam int NS  = 1 << (DL - 6);

        lutram_fifo_ctrl_if #(.WIDTH(8), .DEPTH_LOG2(DL)) bus ();

        lutram_fifo_ctrl #(.WIDTH(8), .DEPTH_LOG2(DL)) dut (
            .CLK (clk),
            .RST (rst),
            .bus (bus)
        );

        assign bus.IN_DATA   = idata;
        assign bus.IN_VALID  = iv;
        assign bus.OUT_READY = ordy;

        // Behavioural RAMD64E bank: synchronous write, asynchronous read.
        logic [7:0] mem [4][64];

        always @(posedge clk) begin
            if (bus.RAM_WE) begin
                mem[bus.RAM_WADR[7:6]][bus.RAM_WADR[5:0]] <= bus.RAM_I;
            end
        end

        always_comb begin
            for (int s = 0; s < NS; s++) begin
                bus.RAM_O[s*8 +: 8] = mem[s][bus.RAM_RADR];
            end
        end

        // Reference model: storage queue plus a one-word output slot.
        logic [7:0] rq [$];
        bit         m_ov;
        logic [7:0] m_od;
        int         wcnt;
        int         lcnt;
        bit         armed;

        initial begin
            bit ld;
            bit wr;
            armed = 1'b0;
            m_ov  = 1'b0;
            m_od  = '0;
            wcnt  = 0;
            lcnt  = 0;
            forever begin
                @(posedge clk);
                if (rst) begin
                    rq.delete();
                    m_ov  = 1'b0;
                    m_od  = '0;
                    wcnt  = 0;
                    lcnt  = 0;
                    armed = 1'b1;
                end else begin
                    ld = (rq.size() != 0) && (!m_ov || ordy);
                    wr = iv && (rq.size() != CAP);
                    if (ld) begin
                        m_od = rq.pop_front();
                        m_ov = 1'b1;
                        lcnt++;
                    end else if (m_ov && ordy) begin
                        m_ov = 1'b0;
                    end
                    if (wr) begin
                        rq.push_back(idata);
                        wcnt++;
                    end
                end
            end
        end

        initial begin
            bit exp_rdy;
            forever begin
                @(negedge clk);
                if (armed) begin
                    exp_rdy = !rst && (rq.size() != CAP);
                    chk("in_ready",  gi, 32'(bus.IN_READY),  32'(exp_rdy));
                    chk("ram_we",    gi, 32'(bus.RAM_WE),    32'(iv && exp_rdy));
                    chk("ram_i",     gi, 32'(bus.RAM_I),     32'(idata));
                    chk("ram_wadr",  gi, 32'(bus.RAM_WADR),  32'(wcnt % CAP));
                    chk("ram_radr",  gi, 32'(bus.RAM_RADR),  32'(lcnt % 64));
                    chk("out_valid", gi, 32'(bus.OUT_VALID), 32'(m_ov));
                    chk("out_data",  gi, 32'(bus.OUT_DATA),  32'(m_od));
                    chk("level",     gi, 32'(bus.LEVEL),     32'(rq.size()) + 32'(m_ov));
                    if (m_ov && ordy && !rst) begin
                        $display("[d%0d] t=%0t pop %02h level=%0d", gi, $time, m_od, rq.size() + int'(m_ov));
                    end
                end
            end
        end
    end

    task automatic drive(input bit r, input bit v, input logic [7:0] d, input bit o);
        rst   = r;
        iv    = v;
        idata = d;
        ordy  = o;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        iv    = 1'b0;
        ordy  = 1'b0;
        idata = '0;
        #1;
        drive(1, 0, 8'h00, 0);
        drive(1, 0, 8'h00, 0);

        // Single word fall-through.
        drive(0, 1, 8'hA5, 0);
        repeat (3) drive(0, 0, 8'h00, 0);
        repeat (2) drive(0, 0, 8'h00, 1);

        // Fill both depths to full with the consumer stalled, then drain.
        for (int i = 0; i < 270; i++) drive(0, 1, 8'(i), 0);
        for (int i = 0; i < 270; i++) drive(0, 0, 8'h00, 1);

        // Continuous streaming across space and pointer wrap.
        for (int i = 0; i < 310; i++) drive(0, 1, 8'(i + 3), 1);
        repeat (5) drive(0, 0, 8'h00, 1);

        // Random traffic with backpressure.
        for (int i = 0; i < 1000; i++) begin
            drive(0, $urandom_range(3, 0) != 0, 8'($urandom), $urandom_range(2, 0) != 0);
        end

        // Random traffic around the full boundary of the small instance.
        for (int i = 0; i < 80; i++) drive(0, 1, 8'($urandom), 0);
        for (int i = 0; i < 200; i++) drive(0, 1, 8'($urandom), $urandom_range(1, 0) != 0);

        // Reset mid-operation with a write pending.
        for (int i = 0; i < 300; i++) drive(0, 0, 8'h00, 1);
        for (int i = 0; i < 10; i++) drive(0, 1, 8'(8'h50 + i), 0);
        drive(1, 1, 8'h77, 0);
        drive(1, 1, 8'h78, 1);
        drive(0, 1, 8'h3C, 0);
        repeat (2) drive(0, 0, 8'h00, 0);
        repeat (4) drive(0, 0, 8'h00, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
